// File: rtl/demux1x2_pair.sv
// Splits a byte stream into even/odd lanes, emitted together as a registered pair one edge after the odd byte.
// No backpressure; a lone trailing byte is flushed on lane 0 after TIMEOUT idle cycles.
module demux1x2_pair #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             valid,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [1:0]       validout
);

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   if (TIMEOUT < 0 || TIMEOUT >= (1 << CNT_W)) begin : g_cfg_err
      $error("demux1x2_pair: TIMEOUT %0d does not fit in CNT_W %0d", TIMEOUT, CNT_W);
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   out0_q, out0_d;
   logic [WIDTH-1:0]   out1_q, out1_d;
   logic [1:0]         vld_q, vld_d;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      out0_d  = out0_q;
      out1_d  = out1_q;
      vld_d   = 2'b00;
      case (state_q)
         EMPTY: begin
            if (valid) begin
               hold_d  = in;
               cnt_d   = '0;
               state_d = HALF;
            end
         end
         HALF: begin
            // A byte arriving on the expiry cycle completes the pair instead of flushing.
            if (valid) begin
               out0_d  = hold_q;
               out1_d  = in;
               vld_d   = 2'b11;
               state_d = EMPTY;
            end else if (TIMEOUT != 0) begin
               if (cnt_q == LAST) begin
                  out0_d  = hold_q;
                  out1_d  = '0;
                  vld_d   = 2'b01;
                  cnt_d   = '0;
                  state_d = EMPTY;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         hold_q  <= '0;
         cnt_q   <= '0;
         out0_q  <= '0;
         out1_q  <= '0;
         vld_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         out0_q  <= out0_d;
         out1_q  <= out1_d;
         vld_q   <= vld_d;
      end
   end

   assign out0     = out0_q;
   assign out1     = out1_q;
   assign validout = vld_q;

endmodule

// File: tb/tb_demux1x2_pair.sv
// Bench for demux1x2_pair: directed scenarios plus random traffic against a pairing/timeout reference.
module tb_demux1x2_pair;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in;
   logic             valid;
   logic [WIDTH-1:0] out0;
   logic [WIDTH-1:0] out1;
   logic [1:0]       validout;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference: a pending-byte slot and an idle count since that byte arrived.
   bit               m_have;
   logic [WIDTH-1:0] m_pend;
   int               m_idle;
   logic [WIDTH-1:0] m_o0, m_o1;
   logic [1:0]       m_vo;

   demux1x2_pair #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .valid    (valid),
      .out0     (out0),
      .out1     (out1),
      .validout (validout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_have = 0;
      m_pend = '0;
      m_idle = 0;
      m_o0   = '0;
      m_o1   = '0;
      m_vo   = 2'b00;
   endtask

   task automatic model_step(input bit v, input logic [WIDTH-1:0] d);
      m_vo = 2'b00;
      if (v) begin
         if (m_have) begin
            m_o0 = m_pend;
            m_o1 = d;
            m_vo = 2'b11;
            m_have = 0;
         end else begin
            m_have = 1;
            m_pend = d;
            m_idle = 0;
         end
      end else if (m_have && TIMEOUT != 0) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            m_o0 = m_pend;
            m_o1 = '0;
            m_vo = 2'b01;
            m_have = 0;
         end
      end
   endtask

   // Drive one cycle, advance the reference, and compare all outputs just after the edge.
   task automatic cycle(input bit v, input logic [WIDTH-1:0] d);
      valid = v;
      in    = d;
      @(posedge clk);
      model_step(v, d);
      #1;
      chk("validout", {30'd0, validout}, {30'd0, m_vo});
      chk("out0", {24'd0, out0}, {24'd0, m_o0});
      chk("out1", {24'd0, out1}, {24'd0, m_o1});
   endtask

   initial begin
      int p;
      reset = 1'b0;
      valid = 1'b0;
      in    = '0;
      model_reset();

      // Outputs stay cleared while reset is held, whatever the inputs do.
      repeat (4) begin
         valid = 1'($urandom);
         in    = WIDTH'($urandom);
         @(posedge clk);
         #1;
         chk("rst_out", {8'd0, out0, out1, 6'd0, validout}, 32'd0);
      end
      valid = 1'b0;
      reset = 1'b1;

      cycle(1, 8'hA1);
      chk("a1_pending", {30'd0, validout}, 32'd0);
      cycle(1, 8'hB2);
      chk("pair_a1b2", {14'd0, validout, out0, out1}, {14'd0, 2'b11, 8'hA1, 8'hB2});

      for (int i = 1; i <= 6; i++) begin
         cycle(1, WIDTH'(i));
         if (i % 2 == 0)
            chk("stream_pair", {14'd0, validout, out0, out1},
                {14'd0, 2'b11, WIDTH'(i - 1), WIDTH'(i)});
         else
            chk("stream_gap", {30'd0, validout}, 32'd0);
      end

      cycle(1, 8'h5C);
      repeat (TIMEOUT - 1) cycle(0, 8'h00);
      chk("pre_flush", {30'd0, validout}, 32'd0);
      cycle(0, 8'h00);
      chk("flush_5c", {14'd0, validout, out0, out1}, {14'd0, 2'b01, 8'h5C, 8'h00});
      cycle(0, 8'h00);
      chk("flush_pulse", {30'd0, validout}, 32'd0);
      cycle(1, 8'hAA);
      cycle(1, 8'hBB);
      chk("after_flush", {14'd0, validout, out0, out1}, {14'd0, 2'b11, 8'hAA, 8'hBB});

      cycle(1, 8'h11);
      repeat (TIMEOUT - 1) cycle(0, 8'h00);
      cycle(1, 8'h22);
      chk("expiry_pair", {14'd0, validout, out0, out1}, {14'd0, 2'b11, 8'h11, 8'h22});
      repeat (TIMEOUT + 2) begin
         cycle(0, 8'h00);
         chk("no_late_flush", {30'd0, validout}, 32'd0);
      end

      cycle(1, 8'h77);
      reset = 1'b0;
      #2;
      chk("async_rst", {8'd0, out0, out1, 6'd0, validout}, 32'd0);
      model_reset();
      #1;
      reset = 1'b1;
      cycle(1, 8'h33);
      cycle(1, 8'h44);
      chk("post_rst_pair", {14'd0, validout, out0, out1}, {14'd0, 2'b11, 8'h33, 8'h44});

      // Random traffic in phases of dense, mixed and sparse valid to reach the timeout path.
      for (int blk = 0; blk < 12; blk++) begin
         p = (blk % 3 == 0) ? 90 : (blk % 3 == 1) ? 50 : 8;
         repeat (200) cycle($urandom_range(0, 99) < p, WIDTH'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
